ysyx_22050598_pipe_ctrl: RTL and testbench
==========================================

# ysyx_22050598_pipe_ctrl

Central pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB). It combines the ID-stage load-use stall from the operand-forwarding unit with EX branch redirects, multi-cycle mul/div occupancy, LSU wait states and WB traps. From these it drives per-stage stall (hold) and bubble (load NOP) controls plus a registered PC redirect to IFU. A small FSM sequences the multi-cycle cases; the remaining controls are combinational from state and inputs.

## Interface
- `PC_W`, default 64: PC width.
- `CNT_W`, default 32: performance counter width (used only with `YSYX_22050598_PERF_CNT_EN`).

Ports:
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `load_stall_signal` in 1: ID source matches an EX load rd (from forwarding unit).
- `ex_redirect_valid` in 1: EX resolved a taken branch or jump.
- `ex_redirect_pc` in PC_W: EX redirect target.
- `ex_md_start` in 1: mul/div instruction is in EX this cycle.
- `ex_md_done` in 1: mul/div result is available this cycle.
- `mem_req` in 1: MEM-stage LSU access is active.
- `mem_ready` in 1: LSU access completes this cycle.
- `wb_trap_valid` in 1: WB takes a trap or mret.
- `wb_trap_pc` in PC_W: trap or mret target.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem` out 1 each: hold the PC, IF/ID, ID/EX and EX/MEM registers respectively.
- `bubble_id`, `bubble_ex`, `bubble_mem`, `bubble_wb` out 1 each: the named stage register loads a NOP.
- `mem_kill` out 1: abort the in-flight LSU access.
- `redirect_valid` out 1 (registered): PC loads `redirect_pc`.
- `redirect_pc` out PC_W (registered): redirect target.
- `perf_load_stall`, `perf_md_stall`, `perf_mem_stall`, `perf_flush` out CNT_W each: event counters.

## Operation
Definitions:
- `mem_hold` = `mem_req` & ~`mem_ready`.
- Any control not named in a rule is 0.

FSM states:
- RUN (reset state)
- MD_WAIT
- FLUSH

Priority, highest first:
1. `wb_trap_valid`, in any state:
   - Outputs: `bubble_id`, `bubble_ex`, `bubble_mem`; `mem_kill` = `mem_req`.
   - Latch `wb_trap_pc` for redirect.
   - Next state FLUSH.
   - Overrides `mem_hold`.
2. `mem_hold`, in any state:
   - Outputs: `stall_if`, `stall_id`, `stall_ex`, `stall_mem`, `bubble_wb`.
   - FSM frozen: no transitions, no latching.
   - `redirect_valid` keeps its current value.
3. State-specific behaviour:
   - **RUN + `ex_redirect_valid`:**
     - Outputs: `bubble_id`, `bubble_ex`.
     - Latch `ex_redirect_pc`.
     - Next state FLUSH.
   - **RUN + `ex_md_start` & ~`ex_md_done`:**
     - Outputs: `stall_if`, `stall_id`, `stall_ex`, `bubble_mem`.
     - Next state MD_WAIT.
   - **RUN + `ex_md_start` & `ex_md_done`:** no stall; stay in RUN.
   - **RUN + `load_stall_signal`:**
     - Outputs: `stall_if`, `stall_id`, `bubble_ex`.
     - Stay in RUN. Exactly one bubble, because the load then moves to MEM and forwarding resolves the dependency.
   - **RUN, none of the above:** all controls 0.
   - **MD_WAIT + ~`ex_md_done`:** outputs `stall_if`, `stall_id`, `stall_ex`, `bubble_mem`.
   - **MD_WAIT + `ex_md_done`:** no stall; next state RUN.
   - **MD_WAIT:** `load_stall_signal` and `ex_redirect_valid` are ignored.
   - **FLUSH:**
     - Outputs: `bubble_id`, which kills the wrong-path fetch issued while the PC was not yet updated.
     - `redirect_valid` = 1.
     - Next state RUN.
     - `load_stall_signal`, `ex_redirect_valid` and `ex_md_start` are ignored.
   - **Within RUN:** `ex_redirect_valid` > `ex_md_start` > `load_stall_signal`.

Registered redirect:
- `redirect_valid` is 1 exactly while state is FLUSH.
- `redirect_pc` holds the latched target.
- A trap arriving during FLUSH re-latches `wb_trap_pc` and stays in FLUSH, so the redirect is extended by one cycle with the new target.

## Timing
- Reset values:
  - State RUN.
  - `redirect_valid` 0, `redirect_pc` 0, all counters 0.
  - While `rst` is high: all `bubble_*` = 1, all `stall_*` = 0, `mem_kill` = 0.
- Reset asserted mid-FLUSH or mid-MD_WAIT returns to RUN at the next edge.
- Stall, bubble and `mem_kill` are combinational, with zero-cycle latency from the inputs.
- Redirect latency:
  - Redirect request at cycle N gives `redirect_valid` at N+1.
  - The PC holds the target at N+2.
  - Extended by any `mem_hold` cycles.
- Penalties:
  - Load-use costs 1 cycle.
  - Branch redirect costs 2 bubbles (ID at N and N+1; EX at N).
  - Mul/div costs (done cycle − start cycle) stall cycles.
- `stall_X` and `bubble_X` are never both 1 for the same register.

## Configuration
`YSYX_22050598_PERF_CNT_EN`:
- **Defined:**
  - `perf_load_stall` increments on rule 3 load stall.
  - `perf_md_stall` increments on each MD stall cycle.
  - `perf_mem_stall` increments on each `mem_hold` cycle.
  - `perf_flush` increments on each entry into FLUSH.
  - All counters wrap modulo 2^CNT_W.
- **Undefined:** the counters are not built and all `perf_*` outputs are constant 0.
- Pipeline control behaviour is identical either way.

## Test plan
- Load-use: `load_stall_signal`=1 for one cycle in RUN -> `stall_if`=`stall_id`=`bubble_ex`=1 that cycle; next cycle all 0; `perf_load_stall`=1.
- Branch: `ex_redirect_valid`=1, `ex_redirect_pc`=0x8000_0040 at N -> `bubble_id`/`bubble_ex` at N; `redirect_valid`=1, `redirect_pc`=0x8000_0040, `bubble_id`=1 at N+1; RUN at N+2.
- Mul/div: `ex_md_start` at N, `ex_md_done` at N+5 -> `stall_if`/`stall_id`/`stall_ex`/`bubble_mem` for N..N+4; no stall at N+5; `perf_md_stall`=5.
- LSU wait during FLUSH: `mem_hold` for 3 cycles while in FLUSH -> `redirect_valid` held 4 cycles total; `bubble_wb`=1 during the hold; `perf_mem_stall`=3.
- Trap vs mem wait: `wb_trap_valid`=1 with `mem_req`=1, `mem_ready`=0 -> `mem_kill`=1; `bubble_id`/`bubble_ex`/`bubble_mem`=1; `stall_*`=0; next cycle `redirect_pc`=`wb_trap_pc`.
- Reset mid-MD_WAIT: `rst`=1 for one edge -> state RUN; `redirect_valid`=0; counters 0; all bubbles 1 while `rst` is high.

Source files
------------

// File: rtl/ysyx_22050598_pipe_ctrl.sv
// Pipeline hazard controller: stall/bubble/kill generation and registered PC redirect.
// Optional event counters are built when YSYX_22050598_PERF_CNT_EN is defined.
module ysyx_22050598_pipe_ctrl #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_stall_signal,
  input  logic             ex_redirect_valid,
  input  logic [PC_W-1:0]  ex_redirect_pc,
  input  logic             ex_md_start,
  input  logic             ex_md_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_trap_valid,
  input  logic [PC_W-1:0]  wb_trap_pc,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             bubble_id,
  output logic             bubble_ex,
  output logic             bubble_mem,
  output logic             bubble_wb,
  output logic             mem_kill,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] perf_load_stall,
  output logic [CNT_W-1:0] perf_md_stall,
  output logic [CNT_W-1:0] perf_mem_stall,
  output logic [CNT_W-1:0] perf_flush
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            rv_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            mem_hold;

  assign mem_hold       = mem_req & ~mem_ready;
  assign redirect_valid = rv_q;
  assign redirect_pc    = pc_q;

  // Prioritised hazard decode: trap, then LSU wait, then per-state rules.
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    bubble_id  = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;
    bubble_wb  = 1'b0;
    mem_kill   = 1'b0;
    state_d    = state_q;
    pc_d       = pc_q;
    if (rst) begin
      bubble_id  = 1'b1;
      bubble_ex  = 1'b1;
      bubble_mem = 1'b1;
      bubble_wb  = 1'b1;
      state_d    = RUN;
    end else if (wb_trap_valid) begin
      bubble_id  = 1'b1;
      bubble_ex  = 1'b1;
      bubble_mem = 1'b1;
      mem_kill   = mem_req;
      pc_d       = wb_trap_pc;
      state_d    = FLUSH;
    end else if (mem_hold) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      stall_ex   = 1'b1;
      stall_mem  = 1'b1;
      bubble_wb  = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_redirect_valid) begin
            bubble_id = 1'b1;
            bubble_ex = 1'b1;
            pc_d      = ex_redirect_pc;
            state_d   = FLUSH;
          end else if (ex_md_start) begin
            if (!ex_md_done) begin
              stall_if   = 1'b1;
              stall_id   = 1'b1;
              stall_ex   = 1'b1;
              bubble_mem = 1'b1;
              state_d    = MD_WAIT;
            end
          end else if (load_stall_signal) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        MD_WAIT: begin
          if (ex_md_done) begin
            state_d = RUN;
          end else begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
          end
        end
        FLUSH: begin
          bubble_id = 1'b1;
          state_d   = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State and redirect registers; redirect_valid mirrors the FLUSH state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      rv_q    <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      rv_q    <= (state_d == FLUSH);
      pc_q    <= pc_d;
    end
  end

`ifdef YSYX_22050598_PERF_CNT_EN
  logic            act;
  logic            ev_load, ev_md, ev_mem, ev_flush;
  logic [CNT_W-1:0] c_load_q, c_md_q, c_mem_q, c_flush_q;

  assign act      = ~rst & ~wb_trap_valid & ~mem_hold;
  assign ev_load  = act & (state_q == RUN) & ~ex_redirect_valid
                  & ~ex_md_start & load_stall_signal;
  assign ev_md    = act & (((state_q == RUN) & ~ex_redirect_valid
                  & ex_md_start & ~ex_md_done)
                  | ((state_q == MD_WAIT) & ~ex_md_done));
  assign ev_mem   = ~rst & ~wb_trap_valid & mem_hold;
  assign ev_flush = ~rst & (wb_trap_valid
                  | (act & (state_q == RUN) & ex_redirect_valid));

  // Wrapping event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_load_q  <= '0;
      c_md_q    <= '0;
      c_mem_q   <= '0;
      c_flush_q <= '0;
    end else begin
      c_load_q  <= c_load_q + CNT_W'(ev_load);
      c_md_q    <= c_md_q + CNT_W'(ev_md);
      c_mem_q   <= c_mem_q + CNT_W'(ev_mem);
      c_flush_q <= c_flush_q + CNT_W'(ev_flush);
    end
  end

  assign perf_load_stall = c_load_q;
  assign perf_md_stall   = c_md_q;
  assign perf_mem_stall  = c_mem_q;
  assign perf_flush      = c_flush_q;
`else
  assign perf_load_stall = '0;
  assign perf_md_stall   = '0;
  assign perf_mem_stall  = '0;
  assign perf_flush      = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050598_pipe_ctrl.sv
// Directed testbench for ysyx_22050598_pipe_ctrl.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_ysyx_22050598_pipe_ctrl;

`ifdef YSYX_22050598_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctl = {stall_if,stall_id,stall_ex,stall_mem,
  //        bubble_id,bubble_ex,bubble_mem,bubble_wb,mem_kill}
  localparam logic [8:0] C_NONE = 9'b0000_0000_0;
  localparam logic [8:0] C_LOAD = 9'b1100_0100_0;
  localparam logic [8:0] C_BR   = 9'b0000_1100_0;
  localparam logic [8:0] C_MD   = 9'b1110_0010_0;
  localparam logic [8:0] C_FL   = 9'b0000_1000_0;
  localparam logic [8:0] C_HOLD = 9'b1111_0001_0;
  localparam logic [8:0] C_TRK  = 9'b0000_1110_1;
  localparam logic [8:0] C_TRP  = 9'b0000_1110_0;
  localparam logic [8:0] C_RST  = 9'b0000_1111_0;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_stall_signal;
  logic        ex_redirect_valid;
  logic [63:0] ex_redirect_pc;
  logic        ex_md_start;
  logic        ex_md_done;
  logic        mem_req;
  logic        mem_ready;
  logic        wb_trap_valid;
  logic [63:0] wb_trap_pc;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        bubble_id, bubble_ex, bubble_mem, bubble_wb;
  logic        mem_kill;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] perf_load_stall, perf_md_stall;
  logic [31:0] perf_mem_stall, perf_flush;
  logic [8:0]  ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctl = {stall_if, stall_id, stall_ex, stall_mem,
                bubble_id, bubble_ex, bubble_mem, bubble_wb, mem_kill};

  ysyx_22050598_pipe_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .load_stall_signal (load_stall_signal),
    .ex_redirect_valid (ex_redirect_valid),
    .ex_redirect_pc    (ex_redirect_pc),
    .ex_md_start       (ex_md_start),
    .ex_md_done        (ex_md_done),
    .mem_req           (mem_req),
    .mem_ready         (mem_ready),
    .wb_trap_valid     (wb_trap_valid),
    .wb_trap_pc        (wb_trap_pc),
    .stall_if          (stall_if),
    .stall_id          (stall_id),
    .stall_ex          (stall_ex),
    .stall_mem         (stall_mem),
    .bubble_id         (bubble_id),
    .bubble_ex         (bubble_ex),
    .bubble_mem        (bubble_mem),
    .bubble_wb         (bubble_wb),
    .mem_kill          (mem_kill),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .perf_load_stall   (perf_load_stall),
    .perf_md_stall     (perf_md_stall),
    .perf_mem_stall    (perf_mem_stall),
    .perf_flush        (perf_flush)
  );

  task automatic idle_inputs();
    load_stall_signal = 1'b0;
    ex_redirect_valid = 1'b0;
    ex_redirect_pc    = '0;
    ex_md_start       = 1'b0;
    ex_md_done        = 1'b0;
    mem_req           = 1'b0;
    mem_ready         = 1'b0;
    wb_trap_valid     = 1'b0;
    wb_trap_pc        = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RST) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 64'd0) begin
      errors++;
      $display("FAIL reset_redir got=%b/%h exp=0/0",
               redirect_valid, redirect_pc);
    end
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=%b", ctl, C_NONE);
    end
    checks++;
    if ({perf_load_stall, perf_md_stall, perf_mem_stall, perf_flush}
        !== 128'd0) begin
      errors++;
      $display("FAIL reset_perf got=%0d/%0d/%0d/%0d exp=0",
               perf_load_stall, perf_md_stall, perf_mem_stall, perf_flush);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    load_stall_signal = 1'b1;
    #1;
    checks++;
    if (ctl !== C_LOAD) begin
      errors++;
      $display("FAIL load_stall got=%b exp=%b", ctl, C_LOAD);
    end
    @(negedge clk);
    load_stall_signal = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL load_after got=%b exp=%b", ctl, C_NONE);
    end
    checks++;
    if (perf_load_stall !== (PERF ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL load_perf got=%0d exp=%0d",
               perf_load_stall, PERF ? 1 : 0);
    end
  endtask

  task automatic test_branch();
    do_reset();
    ex_redirect_valid = 1'b1;
    ex_redirect_pc    = 64'h8000_0040;
    load_stall_signal = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BR || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_n got=%b/%b exp=%b/0", ctl, redirect_valid, C_BR);
    end
    @(negedge clk);
    ex_redirect_valid = 1'b0;
    ex_redirect_pc    = 64'h0;
    ex_md_start       = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FL) begin
      errors++;
      $display("FAIL br_flush_ctl got=%b exp=%b", ctl, C_FL);
    end
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0040) begin
      errors++;
      $display("FAIL br_redir got=%b/%h exp=1/80000040",
               redirect_valid, redirect_pc);
    end
    @(negedge clk);
    load_stall_signal = 1'b0;
    ex_md_start       = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_run got=%b/%b exp=%b/0", ctl, redirect_valid, C_NONE);
    end
    checks++;
    if (perf_flush !== (PERF ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL br_perf got=%0d exp=%0d", perf_flush, PERF ? 1 : 0);
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    ex_md_start       = 1'b1;
    ex_md_done        = 1'b1;
    load_stall_signal = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL md_fast got=%b exp=%b", ctl, C_NONE);
    end
    @(negedge clk);
    ex_md_done        = 1'b0;
    load_stall_signal = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ex_redirect_valid = (i == 2);
      load_stall_signal = (i == 3);
      #1;
      checks++;
      if (ctl !== C_MD || redirect_valid !== 1'b0) begin
        errors++;
        $display("FAIL md_stall[%0d] got=%b/%b exp=%b/0",
                 i, ctl, redirect_valid, C_MD);
      end
      @(negedge clk);
      ex_md_start = 1'b0;
    end
    ex_redirect_valid = 1'b0;
    load_stall_signal = 1'b0;
    ex_md_done        = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL md_done got=%b exp=%b", ctl, C_NONE);
    end
    @(negedge clk);
    ex_md_done        = 1'b0;
    load_stall_signal = 1'b1;
    #1;
    checks++;
    if (ctl !== C_LOAD) begin
      errors++;
      $display("FAIL md_back_run got=%b exp=%b", ctl, C_LOAD);
    end
    checks++;
    if (perf_md_stall !== (PERF ? 32'd5 : 32'd0)) begin
      errors++;
      $display("FAIL md_perf got=%0d exp=%0d", perf_md_stall, PERF ? 5 : 0);
    end
    @(negedge clk);
    load_stall_signal = 1'b0;
  endtask

  task automatic test_flush_mem_wait();
    do_reset();
    ex_redirect_valid = 1'b1;
    ex_redirect_pc    = 64'h0000_0000_0000_1000;
    @(negedge clk);
    ex_redirect_valid = 1'b0;
    mem_req           = 1'b1;
    mem_ready         = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== C_HOLD || redirect_valid !== 1'b1) begin
        errors++;
        $display("FAIL fl_hold[%0d] got=%b/%b exp=%b/1",
                 i, ctl, redirect_valid, C_HOLD);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FL || redirect_valid !== 1'b1
        || redirect_pc !== 64'h1000) begin
      errors++;
      $display("FAIL fl_last got=%b/%b/%h exp=%b/1/1000",
               ctl, redirect_valid, redirect_pc, C_FL);
    end
    @(negedge clk);
    mem_req   = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL fl_end got=%b/%b exp=%b/0", ctl, redirect_valid, C_NONE);
    end
    checks++;
    if (perf_mem_stall !== (PERF ? 32'd3 : 32'd0)) begin
      errors++;
      $display("FAIL fl_perf got=%0d exp=%0d", perf_mem_stall, PERF ? 3 : 0);
    end
  endtask

  task automatic test_trap_mem();
    do_reset();
    wb_trap_valid = 1'b1;
    wb_trap_pc    = 64'h0000_0000_0000_1234;
    mem_req       = 1'b1;
    mem_ready     = 1'b0;
    #1;
    checks++;
    if (ctl !== C_TRK) begin
      errors++;
      $display("FAIL trap_kill got=%b exp=%b", ctl, C_TRK);
    end
    @(negedge clk);
    mem_req       = 1'b0;
    wb_trap_valid = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h1234
        || ctl !== C_FL) begin
      errors++;
      $display("FAIL trap_redir got=%b/%h/%b exp=1/1234/%b",
               redirect_valid, redirect_pc, ctl, C_FL);
    end
    wb_trap_valid = 1'b1;
    wb_trap_pc    = 64'h0000_0000_0000_5678;
    #1;
    checks++;
    if (ctl !== C_TRP) begin
      errors++;
      $display("FAIL trap_in_flush got=%b exp=%b", ctl, C_TRP);
    end
    @(negedge clk);
    wb_trap_valid = 1'b0;
    #1;
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h5678) begin
      errors++;
      $display("FAIL trap_ext got=%b/%h exp=1/5678",
               redirect_valid, redirect_pc);
    end
    @(negedge clk);
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || ctl !== C_NONE) begin
      errors++;
      $display("FAIL trap_end got=%b/%b exp=0/%b",
               redirect_valid, ctl, C_NONE);
    end
  endtask

  task automatic test_reset_mid_md();
    do_reset();
    ex_md_start = 1'b1;
    @(negedge clk);
    ex_md_start = 1'b0;
    #1;
    checks++;
    if (ctl !== C_MD) begin
      errors++;
      $display("FAIL rmd_wait got=%b exp=%b", ctl, C_MD);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RST) begin
      errors++;
      $display("FAIL rmd_rst_ctl got=%b exp=%b", ctl, C_RST);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmd_run got=%b/%b exp=%b/0", ctl, redirect_valid, C_NONE);
    end
    checks++;
    if (perf_md_stall !== 32'd0) begin
      errors++;
      $display("FAIL rmd_perf got=%0d exp=0", perf_md_stall);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_flush_mem_wait();
    test_trap_mem();
    test_reset_mid_md();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
